// File: rtl/arillabus_pkg.sv
// Shared types, widths and defaults for the ArillaBus two-master arbiter.
// Lane helpers extract one master's slice from the packed per-master buses.
package arillabus_pkg;

    localparam int unsigned NUM_MASTERS     = 2;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned BE_W            = DATA_W / 8;
    localparam int unsigned WAIT_CYCLES_DEF = 1;
    localparam int unsigned LOCK_MAX_DEF    = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    function automatic logic [DATA_W-1:0] lane_data(input logic [NUM_MASTERS*DATA_W-1:0] v,
                                                     input logic idx);
        return idx ? v[2*DATA_W-1:DATA_W] : v[DATA_W-1:0];
    endfunction

    function automatic logic [BE_W-1:0] lane_be(input logic [NUM_MASTERS*BE_W-1:0] v,
                                                 input logic idx);
        return idx ? v[2*BE_W-1:BE_W] : v[BE_W-1:0];
    endfunction

endpackage

// File: rtl/arillabus_rr_pick.sv
// Combinational two-way round-robin pick; a held bus lock narrows the
// candidate set to the current owner only.
module arillabus_rr_pick
    import arillabus_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic                   ptr_i,
    input  logic                   lock_en_i,
    output logic                   vld_o,
    output logic                   idx_o
);

    logic [NUM_MASTERS-1:0] elig;

    always_comb begin
        elig = req_i;
        if (lock_en_i) begin
            elig = req_i & (2'b01 << ptr_i);
        end
        vld_o = |elig;
        // On a tie the master that did not win last time goes next.
        idx_o = (elig == 2'b11) ? ~ptr_i : elig[1];
    end

endmodule

// File: rtl/arillabus_arbiter.sv
// Two-master ArillaBus arbiter: round-robin with bounded bus locking,
// IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE, all outputs registered.
module arillabus_arbiter
    import arillabus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int unsigned LOCK_MAX    = LOCK_MAX_DEF
) (
    input  logic                          clk,
    input  logic                          rst_p,
    input  logic [NUM_MASTERS-1:0]        req,
    input  logic [NUM_MASTERS-1:0]        wr,
    input  logic [NUM_MASTERS*ADDR_W-1:0] addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] wdata,
    input  logic [NUM_MASTERS*BE_W-1:0]   be,
    input  logic [NUM_MASTERS-1:0]        lock,
    output logic [NUM_MASTERS-1:0]        ack,
    output logic [DATA_W-1:0]             rdata,
    output logic [NUM_MASTERS-1:0]        gnt,
    output logic                          busy,
    output logic                          RD,
    output logic                          WR,
    output logic [ADDR_W-1:0]             ADDR,
    output logic [BE_W-1:0]               ByteEna,
    output logic [DATA_W-1:0]             DATA_O,
    output logic                          DATA_OE,
    input  logic [DATA_W-1:0]             DATA_I
);

    localparam logic [3:0] WAIT_LAST  = 4'(WAIT_CYCLES);
    localparam logic [8:0] LOCK_LIMIT = 9'(LOCK_MAX);

    state_e                 state_q;
    logic [NUM_MASTERS-1:0] ack_q;
    logic [NUM_MASTERS-1:0] gnt_q;
    logic                   busy_q;
    logic                   rd_q;
    logic                   wr_q;
    logic                   oe_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [BE_W-1:0]        be_q;
    logic [DATA_W-1:0]      dout_q;
    logic [DATA_W-1:0]      rdata_q;
    logic [3:0]             wait_q;
    logic                   ptr_q;
    logic                   locked_q;
    logic [7:0]             lock_cnt_q;

    logic                   lock_en;
    logic                   pick_vld;
    logic                   pick_idx;
    logic [8:0]             lock_cnt_d;
    logic                   lock_keep;

    // ptr_q is both the round-robin pointer and the identity of the lock owner.
    assign lock_en    = locked_q & lock[ptr_q];
    assign lock_cnt_d = {1'b0, lock_cnt_q} + 9'd1;
    assign lock_keep  = lock[ptr_q] && (lock_cnt_d < LOCK_LIMIT);

    arillabus_rr_pick u_pick (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .lock_en_i (lock_en),
        .vld_o     (pick_vld),
        .idx_o     (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_q    <= ST_IDLE;
            ack_q      <= '0;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            oe_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            dout_q     <= '0;
            rdata_q    <= '0;
            wait_q     <= '0;
            ptr_q      <= 1'b1;
            locked_q   <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (locked_q && !lock[ptr_q]) begin
                        locked_q   <= 1'b0;
                        lock_cnt_q <= '0;
                    end
                    if (pick_vld) begin
                        state_q <= ST_ACCESS;
                        busy_q  <= 1'b1;
                        gnt_q   <= 2'b01 << pick_idx;
                        ptr_q   <= pick_idx;
                        rd_q    <= ~wr[pick_idx];
                        wr_q    <= wr[pick_idx];
                        oe_q    <= wr[pick_idx];
                        addr_q  <= lane_data(addr, pick_idx);
                        dout_q  <= lane_data(wdata, pick_idx);
                        be_q    <= lane_be(be, pick_idx);
                        wait_q  <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (wait_q == WAIT_LAST) begin
                        state_q <= ST_DONE;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        oe_q    <= 1'b0;
                        ack_q   <= gnt_q;
                        if (rd_q) begin
                            rdata_q <= DATA_I;
                        end
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    gnt_q   <= '0;
                    if (lock_keep) begin
                        locked_q   <= 1'b1;
                        lock_cnt_q <= lock_cnt_d[7:0];
                    end else begin
                        locked_q   <= 1'b0;
                        lock_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack     = ack_q;
    assign rdata   = rdata_q;
    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign RD      = rd_q;
    assign WR      = wr_q;
    assign ADDR    = addr_q;
    assign ByteEna = be_q;
    assign DATA_O  = dout_q;
    assign DATA_OE = oe_q;

    a_strobe_excl: assert property (@(posedge clk) !(RD && WR));
    a_ack_onehot:  assert property (@(posedge clk) ack != 2'b11);
    a_ack_after_access: assert property (@(posedge clk) disable iff (rst_p)
        (ack != 2'b00) |-> $past(state_q == ST_ACCESS));

endmodule

// File: tb/tb_arillabus_arbiter.sv
// Randomized and directed checks of arillabus_arbiter against a transaction
// timeline model (age since grant) of the bus protocol.
module tb_arillabus_arbiter;

    localparam int unsigned W  = 1;
    localparam int unsigned LM = 3;

    logic        clk = 1'b0;
    logic        rst_p;
    logic [1:0]  req, wr, lock;
    logic [63:0] addr, wdata;
    logic [7:0]  be;
    logic [31:0] data_i;
    logic [1:0]  ack, gnt;
    logic [31:0] rdata, ADDR, DATA_O;
    logic [3:0]  ByteEna;
    logic        busy, RD, WR, DATA_OE;

    always #5 clk = ~clk;

    arillabus_arbiter #(.WAIT_CYCLES(W), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst_p(rst_p), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .be(be), .lock(lock), .ack(ack), .rdata(rdata), .gnt(gnt), .busy(busy),
        .RD(RD), .WR(WR), .ADDR(ADDR), .ByteEna(ByteEna), .DATA_O(DATA_O),
        .DATA_OE(DATA_OE), .DATA_I(data_i)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, got, exp);
        end
    endtask

    // Reference: one transaction in flight, tracked by its age in cycles since grant.
    bit          m_active;
    int unsigned m_age;
    bit          m_owner;
    bit          m_locked;
    int unsigned m_lcnt;
    bit          m_wr;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;

    task automatic model_step();
        logic [1:0] elig;
        int w;
        if (rst_p) begin
            m_active = 0; m_age = 0; m_owner = 1; m_locked = 0; m_lcnt = 0;
            m_wr = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_be = '0;
        end else if (m_active) begin
            m_age++;
            if (m_age == W + 2) begin
                if (!m_wr) m_rdata = data_i;
            end else if (m_age == W + 3) begin
                if (lock[m_owner] && (m_lcnt + 1 < LM)) begin
                    m_locked = 1; m_lcnt++;
                end else begin
                    m_locked = 0; m_lcnt = 0;
                end
                m_active = 0;
            end
        end else begin
            if (m_locked && !lock[m_owner]) begin
                m_locked = 0; m_lcnt = 0;
            end
            elig = m_locked ? (req & (2'b01 << m_owner)) : req;
            if (elig != 2'b00) begin
                if (elig == 2'b11) w = m_owner ? 0 : 1;
                else               w = elig[1] ? 1 : 0;
                m_owner  = (w == 1);
                m_active = 1;
                m_age    = 1;
                m_wr     = wr[w];
                m_addr   = addr[32*w +: 32];
                m_wdata  = wdata[32*w +: 32];
                m_be     = be[4*w +: 4];
            end
        end
    endtask

    task automatic check_outputs();
        bit         acc;
        logic [1:0] e_ack, e_gnt;
        acc   = m_active && (m_age <= W + 1);
        e_ack = (m_active && m_age == W + 2) ? (2'b01 << m_owner) : 2'b00;
        e_gnt = m_active ? (2'b01 << m_owner) : 2'b00;
        check_val("ack",     ack,     e_ack);
        check_val("gnt",     gnt,     e_gnt);
        check_val("busy",    busy,    m_active);
        check_val("RD",      RD,      acc && !m_wr);
        check_val("WR",      WR,      acc && m_wr);
        check_val("DATA_OE", DATA_OE, acc && m_wr);
        check_val("ADDR",    ADDR,    m_addr);
        check_val("ByteEna", ByteEna, m_be);
        check_val("DATA_O",  DATA_O,  m_wdata);
        check_val("rdata",   rdata,   m_rdata);
        check_val("rd_wr_excl", RD && WR, 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        check_outputs();
    endtask

    task automatic set_master(input int i, input bit w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] b);
        wr[i]           = w;
        addr[32*i +: 32] = a;
        wdata[32*i +: 32] = d;
        be[4*i +: 4]    = b;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        logic [1:0] exp_seq [4];
        rst_p = 1; req = 0; wr = 0; lock = 0; addr = 0; wdata = 0; be = 0; data_i = 0;
        cycle(); cycle();
        check_val("rst_gnt", gnt, 0);
        check_val("rst_rdata", rdata, 0);
        rst_p = 0;
        cycle();

        // Core read with a single wait state
        set_master(0, 0, 32'h0000_1000, 32'h0, 4'hF);
        data_i = 32'hDEAD_BEEF;
        req = 2'b01;
        cycle(); check_val("rd_cyc1", RD, 1);
        cycle(); check_val("rd_cyc2", RD, 1);
        cycle(); check_val("rd_ack", ack, 2'b01);
        check_val("rd_data", rdata, 32'hDEAD_BEEF);
        check_val("rd_strobe_off", RD, 0);
        req = 0;
        cycle(); cycle();

        // DMA write, partial byte enables
        set_master(1, 1, 32'h0000_2000, 32'hCAFE_0000, 4'b0011);
        req = 2'b10;
        cycle();
        check_val("wr_WR", WR, 1);
        check_val("wr_RD", RD, 0);
        check_val("wr_OE", DATA_OE, 1);
        check_val("wr_DATA_O", DATA_O, 32'hCAFE_0000);
        check_val("wr_be", ByteEna, 4'b0011);
        cycle(); cycle();
        check_val("wr_ack", ack, 2'b10);
        check_val("wr_rdata_hold", rdata, 32'hDEAD_BEEF);
        req = 0; wr = 0;
        cycle();

        // Both requesting out of reset: strict alternation, core first
        rst_p = 1; req = 2'b11; cycle(); rst_p = 0;
        got = 0;
        for (int c = 0; c < 80 && got < 8; c++) begin
            cycle();
            if (ack != 2'b00) begin
                check_val($sformatf("rr_ack%0d", got), ack, (got % 2 == 0) ? 2'b01 : 2'b10);
                got++;
            end
        end
        check_val("rr_count", got, 8);
        req = 0;
        for (int c = 0; c < 10; c++) cycle();

        // Locked core capped at LOCK_MAX transactions, then DMA
        rst_p = 1; cycle(); rst_p = 0;
        req = 2'b11; lock = 2'b01;
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
        got = 0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            cycle();
            if (ack != 2'b00) begin
                check_val($sformatf("lock_ack%0d", got), ack, exp_seq[got]);
                got++;
                if (got == 4) begin req = 0; lock = 0; end
            end
        end
        check_val("lock_count", got, 4);
        for (int c = 0; c < 10; c++) cycle();

        // Reset in the second ACCESS cycle aborts without ack
        set_master(0, 0, 32'h0000_3000, 32'h0, 4'hF);
        req = 2'b01;
        cycle(); cycle();
        check_val("abort_rd_pre", RD, 1);
        rst_p = 1; req = 0;
        cycle();
        check_val("abort_RD", RD, 0);
        check_val("abort_WR", WR, 0);
        check_val("abort_gnt", gnt, 0);
        check_val("abort_ack", ack, 0);
        rst_p = 0;
        cycle(); check_val("abort_noack", ack, 0);
        cycle(); check_val("abort_noack2", ack, 0);

        // Randomized traffic with lock toggling, drops and occasional reset
        for (int c = 0; c < 3000; c++) begin
            cycle();
            rst_p  = ($urandom_range(0, 499) == 0);
            data_i = $urandom;
            for (int i = 0; i < 2; i++) begin
                if (ack[i]) begin
                    req[i] = 0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    set_master(i, 1'($urandom_range(0, 1)), $urandom, $urandom,
                               4'($urandom_range(0, 15)));
                    req[i] = 1;
                end else if (req[i] && $urandom_range(0, 99) == 0) begin
                    req[i] = 0;
                end
                if ($urandom_range(0, 7) == 0) lock[i] = ~lock[i];
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/arillabus_arbiter.md
ARILLABUS_ARBITER -- requirements
Module: arillabus_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, extra bus cycles RD/WR held beyond the first (legal 0..15).
REQ-002 Parameter LOCK_MAX, default 8, max consecutive locked transactions per owner (legal 1..255).
REQ-003 clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-004 rst_p  input  1  reset, synchronous, active-high.
REQ-005 req  input  2  per-master request; bit 0 = core, bit 1 = DMA/GPU requester.
REQ-006 wr  input  2  per-master direction, 1 = write, 0 = read.
REQ-007 addr  input  64  master n address at [32n+31:32n].
REQ-008 wdata  input  64  master n write data at [32n+31:32n].
REQ-009 be  input  8  master n byte enables at [4n+3:4n].
REQ-010 lock  input  2  per-master bus-lock request (atomic sequences).
REQ-011 ack  output  2  one-cycle completion pulse to owning master.
REQ-012 rdata  output  32  read data, valid when ack pulses for a read.
REQ-013 gnt  output  2  one-hot current owner, 0 when idle.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 RD, WR  output  1 each  bus strobes.
REQ-016 ADDR  output  32; ByteEna  output  4; DATA_O  output  32; DATA_OE  output  1 (drive DATA when high); DATA_I  input  32.

Function
REQ-017 FSM states IDLE, ACCESS, DONE; transitions only as below.
REQ-018 IDLE: if an eligible request exists, pick winner, register its wr/addr/wdata/be onto bus registers, set gnt, go ACCESS next cycle; else stay.
REQ-019 ACCESS lasts exactly WAIT_CYCLES+1 cycles: RD=~wr or WR=wr, ADDR/ByteEna/DATA_O stable, DATA_OE=WR.
REQ-020 Last ACCESS cycle: for reads, DATA_I captured into rdata; for writes rdata unchanged.
REQ-021 DONE: strobes and DATA_OE low, ack[owner]=1 for this cycle only, then IDLE.
REQ-022 Latency: request sampled in IDLE at cycle T -> ack at T+WAIT_CYCLES+2; max throughput one transaction per WAIT_CYCLES+3 cycles.
REQ-023 Handshake: master holds req and fields stable until ack; req dropped mid-transaction is ignored, transaction completes and acks.
REQ-024 RD and WR never high together; ack never on more than one bit; ack never without a preceding ACCESS.
REQ-025 Round robin: pointer holds last granted master; with both requesting and unlocked, grant the other; single requester always granted.
REQ-026 Lock: at DONE, if lock[owner]=1 and lock_cnt+1<LOCK_MAX, set locked and increment lock_cnt; else clear locked and lock_cnt.
REQ-027 While locked only owner is eligible in IDLE; locked clears in IDLE when lock[owner]=0.
REQ-028 After forced release at LOCK_MAX, the other master if requesting wins next arbitration regardless of lock.
REQ-029 be=0 passed through unchanged; block does not decode addresses.

Reset
REQ-030 On rst_p: state IDLE, RD=WR=DATA_OE=0, ADDR=DATA_O=ByteEna=0, ack=0, gnt=0, busy=0, rdata=0, pointer=1 (core wins first tie), locked=0, lock_cnt=0.
REQ-031 Reset mid-ACCESS: strobes low on the next edge, no ack issued for the aborted transaction.

Structure
REQ-032 Shared package arillabus_pkg holds state enum, master count (2), ADDR/DATA widths, default WAIT_CYCLES and LOCK_MAX.
REQ-033 One sub-module arillabus_rr_pick: combinational 2-way round-robin pick from req, pointer, lock mask; FSM, counters, registers stay in top.

Verification
REQ-034 Core read 0x0000_1000, WAIT_CYCLES=1, DATA_I=0xDEADBEEF -> RD high 2 cycles, ack=01 at T+3, rdata=0xDEADBEEF.
REQ-035 Both req at reset exit -> core granted first, then DMA; alternation 01,10,01,10 across four back-to-back pairs.
REQ-036 DMA write 0xCAFE0000 be=0011 -> WR high, DATA_OE high, DATA_O=0xCAFE0000, ByteEna=0011, ack=10, rdata unchanged.
REQ-037 Core lock=1, LOCK_MAX=3, DMA requesting -> core gets 3 consecutive transactions, then DMA granted.
REQ-038 rst_p asserted in 2nd ACCESS cycle -> next cycle all strobes 0, gnt=0, no ack.
